// File: rtl/traffic_sensor_frontend_pkg.sv
// Shared constants for the traffic sensor front-end: light codes, approach
// indices and gap FSM state encoding.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    localparam int unsigned N = 0;
    localparam int unsigned S = 1;
    localparam int unsigned E = 2;
    localparam int unsigned W = 3;

    localparam logic [1:0] ST_WAIT  = 2'd0;
    localparam logic [1:0] ST_GREEN = 2'd1;
    localparam logic [1:0] ST_REQ   = 2'd2;

    function automatic logic light_legal(input logic [2:0] code);
        return (code == LIGHT_RED) || (code == LIGHT_YEL) || (code == LIGHT_GRN);
    endfunction

endpackage

// File: rtl/traffic_sensor_frontend_if.sv
// Detector, light and termination-request bundle between the traffic
// controller environment (master) and the sensor front-end (slave).
interface traffic_sensor_frontend_if #(
    parameter int unsigned QCNT_W = 4
);
    logic [3:0]          arr_raw;
    logic [3:0]          dep_raw;
    logic [2:0]          n_lights;
    logic [2:0]          s_lights;
    logic [2:0]          e_lights;
    logic [2:0]          w_lights;
    logic                x1;
    logic                x2;
    logic                x3;
    logic                x4;
    logic [4*QCNT_W-1:0] queue_cnt;
    logic                err_conflict;

    modport master (
        output arr_raw, dep_raw, n_lights, s_lights, e_lights, w_lights,
        input  x1, x2, x3, x4, queue_cnt, err_conflict
    );

    modport slave (
        input  arr_raw, dep_raw, n_lights, s_lights, e_lights, w_lights,
        output x1, x2, x3, x4, queue_cnt, err_conflict
    );
endinterface

// File: rtl/traffic_sensor_frontend_debounce.sv
// One loop detector channel: 2-flop synchronizer, level debouncer and a
// single-cycle registered pulse on each accepted rising edge.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_a,
    input  logic raw,
    output logic rise
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // the DEBOUNCE_CYCLES-th differing sample commits the new level
                cnt   <= '0;
                level <= sync2;
                rise  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/traffic_sensor_frontend.sv
// Detector front-end: debounced arrival/departure queues per approach and
// gap-out termination requests x1..x4, with a sticky light-conflict flag.
module traffic_sensor_frontend
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES      = 3,
    parameter int unsigned MIN_GREEN       = 4,
    parameter int unsigned QCNT_W          = 4
) (
    input  logic                      clk,
    input  logic                      rst_a,
    traffic_sensor_frontend_if.slave  bus
);
    localparam int unsigned TW = $clog2(MIN_GREEN + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] GT_MAX  = TW'(MIN_GREEN);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);

    logic [3:0]          arr_rise;
    logic [3:0]          dep_rise;
    logic [2:0]          lights [4];
    logic                conflict_now;
    logic [2:0]          not_red;
    logic                err_q;
    logic                hold;
    logic [4*QCNT_W-1:0] q_flat;
    logic [3:0]          x_vec;

    always_comb begin
        lights[N] = bus.n_lights;
        lights[S] = bus.s_lights;
        lights[E] = bus.e_lights;
        lights[W] = bus.w_lights;
    end

    always_comb begin
        not_red      = '0;
        conflict_now = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!light_legal(lights[i])) conflict_now = 1'b1;
            if (lights[i] != LIGHT_RED)  not_red = not_red + 3'd1;
        end
        if (not_red > 3'd1) conflict_now = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a)            err_q <= 1'b0;
        else if (conflict_now) err_q <= 1'b1;
    end

    // the conflicting cycle itself already blocks the FSMs, so x never leaks
    assign hold = err_q | conflict_now;

    for (genvar i = 0; i < 4; i++) begin : g_app
        logic [QCNT_W-1:0] q;
        logic [1:0]        state;
        logic [TW-1:0]     green_tmr;
        logic [GW-1:0]     gap_cnt;
        logic              x_r;
        logic              green;

        sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_arr (
            .clk   (clk),
            .rst_a (rst_a),
            .raw   (bus.arr_raw[i]),
            .rise  (arr_rise[i])
        );

        sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dep (
            .clk   (clk),
            .rst_a (rst_a),
            .raw   (bus.dep_raw[i]),
            .rise  (dep_rise[i])
        );

        assign green = (lights[i] == LIGHT_GRN);

        always_ff @(posedge clk or negedge rst_a) begin
            if (!rst_a) begin
                q <= '0;
            end else if (arr_rise[i] && !dep_rise[i] && (q != '1)) begin
                q <= q + 1'b1;
            end else if (dep_rise[i] && !arr_rise[i] && (q != '0)) begin
                q <= q - 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_a) begin
            if (!rst_a) begin
                state     <= ST_WAIT;
                green_tmr <= '0;
                gap_cnt   <= '0;
                x_r       <= 1'b0;
            end else if (hold || !green) begin
                state     <= ST_WAIT;
                green_tmr <= '0;
                gap_cnt   <= '0;
                x_r       <= 1'b0;
            end else begin
                case (state)
                    ST_WAIT: begin
                        state     <= ST_GREEN;
                        green_tmr <= TW'(1);
                        gap_cnt   <= (q == '0) ? GW'(1) : '0;
                    end
                    ST_GREEN: begin
                        if ((green_tmr >= GT_MAX) && (gap_cnt >= GAP_MAX)) begin
                            state <= ST_REQ;
                            x_r   <= 1'b1;
                        end
                        green_tmr <= (green_tmr >= GT_MAX) ? GT_MAX : green_tmr + 1'b1;
                        if (q != '0)                gap_cnt <= '0;
                        else if (gap_cnt < GAP_MAX) gap_cnt <= gap_cnt + 1'b1;
                    end
                    ST_REQ: begin
                        x_r <= 1'b1;
                    end
                    default: begin
                        state <= ST_WAIT;
                        x_r   <= 1'b0;
                    end
                endcase
            end
        end

        assign q_flat[i*QCNT_W +: QCNT_W] = q;
        assign x_vec[i] = x_r;
    end

    assign bus.queue_cnt    = q_flat;
    assign bus.err_conflict = err_q;
    assign bus.x1           = x_vec[N];
    assign bus.x2           = x_vec[S];
    assign bus.x3           = x_vec[E];
    assign bus.x4           = x_vec[W];
endmodule
